pll_lock_supervisor: RTL and testbench

- Supervises the 50→10 MHz clock PLL from the free-running 50 MHz reference clock.
- Drives the PLL reset and synchronises the asynchronous PLL locked indication.
- Requires lock to be continuously stable before releasing the system reset for the 10 MHz monitoring logic.
- Re-resets the PLL on lock loss or lock timeout, and latches a fault after repeated failures.

---
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on the 50 MHz reference clock.
// Holds the 10 MHz domain in reset until lock has been stable, retries on timeout, latches fault.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [2:0]       state_dbg
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [RW-1:0]    retry_inc;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             locked_s;
    logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

    assign locked_s  = sync2_q;
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_PLL_RESET: begin
                if (timer_q == RST_CYCLES - 1) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == LOCK_TIMEOUT - 1) begin
                    retry_d = retry_inc;
                    timer_d = '0;
                    state_d = (retry_inc == RW'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RESET;
                end
            end
            ST_STABLE: begin
                // Lock drop takes priority over the final count, so a late drop never releases reset.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_CYCLES - 1) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (!locked_s) begin
                    state_d = ST_PLL_RESET;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_PLL_RESET;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
            pll_rst_q <= (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst         = sys_rst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign lock_loss_count = loss_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] lock_loss_count;
    logic [2:0] state_dbg;
    logic [8:0] obs;

    int checks   = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fault          (fault),
        .lock_loss_count(lock_loss_count),
        .state_dbg      (state_dbg)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Snapshot: {pll_rst, sys_rst, ready, fault, lock_loss_count, state_dbg}
    assign obs = {pll_rst, sys_rst, ready, fault, lock_loss_count, state_dbg};

    function automatic logic [8:0] ex(input int s, input int llc);
        logic pr, sr, rd, ft;
        pr = (s == 0) || (s == 4);
        sr = (s != 3);
        rd = (s == 3);
        ft = (s == 4);
        return {pr, sr, rd, ft, 2'(llc), 3'(s)};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL reset_state obs=%b exp=%b", obs, ex(0, 0));
        end
        rst = 1'b0;
    endtask

    task automatic test_pll_reset_pulse();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== ex(0, 0)) begin
                failures++;
                $display("FAIL pll_rst_hold cyc=%0d obs=%b exp=%b", i, obs, ex(0, 0));
            end
        end
        tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL pll_rst_release obs=%b exp=%b", obs, ex(1, 0));
        end
    endtask

    task automatic test_lock();
        repeat (5) tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL wait_before_lock obs=%b exp=%b", obs, ex(1, 0));
        end
        pll_locked = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL sync_latency obs=%b exp=%b", obs, ex(1, 0));
        end
        tick();
        checks++;
        if (obs !== ex(2, 0)) begin
            failures++;
            $display("FAIL stable_entry obs=%b exp=%b", obs, ex(2, 0));
        end
        for (int i = 3; i <= 9; i++) begin
            tick();
            checks++;
            if (obs !== ex(2, 0)) begin
                failures++;
                $display("FAIL stable_hold edge=%0d obs=%b exp=%b", i, obs, ex(2, 0));
            end
        end
        tick();
        checks++;
        if (obs !== ex(3, 0)) begin
            failures++;
            $display("FAIL run_release obs=%b exp=%b", obs, ex(3, 0));
        end
    endtask

    task automatic test_stable_glitch();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== ex(2, 0)) begin
            failures++;
            $display("FAIL glitch_stable_entry obs=%b exp=%b", obs, ex(2, 0));
        end
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        checks++;
        if (obs !== ex(2, 0)) begin
            failures++;
            $display("FAIL glitch_in_flight obs=%b exp=%b", obs, ex(2, 0));
        end
        tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL glitch_back_to_wait obs=%b exp=%b", obs, ex(1, 0));
        end
        tick();
        checks++;
        if (obs !== ex(2, 0)) begin
            failures++;
            $display("FAIL glitch_relock obs=%b exp=%b", obs, ex(2, 0));
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (obs !== ex(2, 0)) begin
                failures++;
                $display("FAIL glitch_fresh_count i=%0d obs=%b exp=%b", i, obs, ex(2, 0));
            end
        end
        tick();
        checks++;
        if (obs !== ex(3, 0)) begin
            failures++;
            $display("FAIL glitch_run obs=%b exp=%b", obs, ex(3, 0));
        end
    endtask

    task automatic test_run_loss();
        int prev;
        int e;
        prev = 0;
        for (int k = 1; k <= 4; k++) begin
            e = (k > 3) ? 3 : k;
            pll_locked = 1'b0;
            tick();
            tick();
            checks++;
            if (obs !== ex(3, prev)) begin
                failures++;
                $display("FAIL loss_sync k=%0d obs=%b exp=%b", k, obs, ex(3, prev));
            end
            tick();
            checks++;
            if (obs !== ex(0, e)) begin
                failures++;
                $display("FAIL loss_reset k=%0d obs=%b exp=%b", k, obs, ex(0, e));
            end
            pll_locked = 1'b1;
            repeat (3) tick();
            checks++;
            if (obs !== ex(0, e)) begin
                failures++;
                $display("FAIL loss_pll_rst_hold k=%0d obs=%b exp=%b", k, obs, ex(0, e));
            end
            tick();
            checks++;
            if (obs !== ex(1, e)) begin
                failures++;
                $display("FAIL loss_wait k=%0d obs=%b exp=%b", k, obs, ex(1, e));
            end
            repeat (8) tick();
            checks++;
            if (obs !== ex(2, e)) begin
                failures++;
                $display("FAIL loss_stable k=%0d obs=%b exp=%b", k, obs, ex(2, e));
            end
            tick();
            checks++;
            if (obs !== ex(3, e)) begin
                failures++;
                $display("FAIL loss_rerun k=%0d obs=%b exp=%b", k, obs, ex(3, e));
            end
            prev = e;
        end
    endtask

    task automatic test_rst_in_run();
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL rst_in_run obs=%b exp=%b", obs, ex(0, 0));
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL rst_in_run_after obs=%b exp=%b", obs, ex(0, 0));
        end
    endtask

    task automatic test_timeout_fault();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        repeat (19) tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL timeout1_last_wait obs=%b exp=%b", obs, ex(1, 0));
        end
        tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL timeout1_retry obs=%b exp=%b", obs, ex(0, 0));
        end
        repeat (3) tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL retry_pll_rst_hold obs=%b exp=%b", obs, ex(0, 0));
        end
        tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL retry_wait obs=%b exp=%b", obs, ex(1, 0));
        end
        repeat (19) tick();
        checks++;
        if (obs !== ex(1, 0)) begin
            failures++;
            $display("FAIL timeout2_last_wait obs=%b exp=%b", obs, ex(1, 0));
        end
        tick();
        checks++;
        if (obs !== ex(4, 0)) begin
            failures++;
            $display("FAIL fault_entry obs=%b exp=%b", obs, ex(4, 0));
        end
        pll_locked = 1'b1;
        repeat (10) tick();
        checks++;
        if (obs !== ex(4, 0)) begin
            failures++;
            $display("FAIL fault_sticky obs=%b exp=%b", obs, ex(4, 0));
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== ex(0, 0)) begin
            failures++;
            $display("FAIL fault_cleared obs=%b exp=%b", obs, ex(0, 0));
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_pll_reset_pulse();
        test_lock();
        test_stable_glitch();
        test_run_loss();
        test_rst_in_run();
        test_timeout_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
